// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life row-serial engine.
package gol_pkg;

    localparam int unsigned RULE_W = 9;
    localparam int unsigned NBR_W  = 4;

    typedef logic [RULE_W-1:0] rule_mask_t;
    typedef logic [NBR_W-1:0]  nbr_cnt_t;

    // Conway's standard rule: born with 3, survives with 2 or 3.
    localparam rule_mask_t RULE_B3  = 9'b000001000;
    localparam rule_mask_t RULE_S23 = 9'b000001100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } gol_state_e;

endpackage

// File: rtl/gol_row_engine_if.sv
// Row stream bundle: current generation in, next generation out.
interface gol_row_engine_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned ROW_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [ROW_W-1:0] out_row;
    logic             out_last;

    // Environment side: supplies rows and sinks results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last
    );

    // Engine side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/gol_row_step.sv
// Combinational next-generation evaluation of one row from its 3-row window.
// GOL_TORUS_EN selects wrap-around columns; otherwise columns past the edge are dead.
module gol_row_step
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] above_i,
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] below_i,
    input  rule_mask_t       birth_i,
    input  rule_mask_t       survive_i,
    output logic [WIDTH-1:0] next_c
);

    // Bit x of the result is column x-1 of the row.
    function automatic logic [WIDTH-1:0] from_west(input logic [WIDTH-1:0] r);
`ifdef GOL_TORUS_EN
        return {r[WIDTH-2:0], r[WIDTH-1]};
`else
        return {r[WIDTH-2:0], 1'b0};
`endif
    endfunction

    // Bit x of the result is column x+1 of the row.
    function automatic logic [WIDTH-1:0] from_east(input logic [WIDTH-1:0] r);
`ifdef GOL_TORUS_EN
        return {r[0], r[WIDTH-1:1]};
`else
        return {1'b0, r[WIDTH-1:1]};
`endif
    endfunction

    logic [WIDTH-1:0] a_w, a_e, c_w, c_e, b_w, b_e;

    assign a_w = from_west(above_i);
    assign a_e = from_east(above_i);
    assign c_w = from_west(cur_i);
    assign c_e = from_east(cur_i);
    assign b_w = from_west(below_i);
    assign b_e = from_east(below_i);

    // Per-column neighbour count and rule lookup.
    for (genvar x = 0; x < WIDTH; x++) begin : g_col
        nbr_cnt_t n;
        assign n = 4'(a_w[x]) + 4'(above_i[x]) + 4'(a_e[x])
                 + 4'(c_w[x])                   + 4'(c_e[x])
                 + 4'(b_w[x]) + 4'(below_i[x]) + 4'(b_e[x]);
        assign next_c[x] = cur_i[x] ? survive_i[n] : birth_i[n];
    end

endmodule

// File: rtl/gol_row_engine.sv
// Streaming Game-of-Life engine: one input row per beat, one output row per beat,
// evaluated through an above/cur/below sliding window.
// Optional macro GOL_TORUS_EN: toroidal grid (rows 0/1 are held back and row 0 is
// emitted last); undefined gives a dead border.
module gol_row_engine
    import gol_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 48,
    parameter int unsigned GEN_W  = 16,
    parameter int unsigned ROW_W  = $clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  rule_mask_t        birth_mask,
    input  rule_mask_t        survive_mask,
    gol_row_engine_if.slave   bus,
    output logic              busy,
    output logic [GEN_W-1:0]  gen_count
);

    typedef logic [WIDTH-1:0] row_t;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

    // Elaboration-time parameter sanity.
    if (WIDTH < 3) begin : g_bad_width
        $error("gol_row_engine: WIDTH must be at least 3");
    end
`ifdef GOL_TORUS_EN
    if (HEIGHT < 3) begin : g_bad_height
        $error("gol_row_engine: HEIGHT must be at least 3 on a torus");
    end
`else
    if (HEIGHT < 2) begin : g_bad_height
        $error("gol_row_engine: HEIGHT must be at least 2");
    end
`endif

    gol_state_e       state_q, state_d;
    row_t             above_q, above_d;
    row_t             cur_q, cur_d;
    row_t             out_data_q, out_data_d;
    logic [ROW_W-1:0] in_row_q, in_row_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    rule_mask_t       birth_q, birth_d;
    rule_mask_t       survive_q, survive_d;
    logic             busy_q;
    logic             ready_en_q;
`ifdef GOL_TORUS_EN
    row_t             row0_q, row0_d;
    row_t             row1_q, row1_d;
    logic             tail_q, tail_d;
`endif

    row_t             below_c;
    row_t             step_c;
    logic             out_free_c;
    logic             in_ready_c;
    logic             accept_c;

    function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
        return (r == LAST_ROW) ? '0 : r + ROW_W'(1);
    endfunction

    assign out_free_c = !out_valid_q || bus.out_ready;
    assign in_ready_c = ready_en_q && out_free_c &&
                        ((state_q == IDLE) || (state_q == FILL) || (state_q == STREAM));
    assign accept_c   = in_ready_c && bus.in_valid;

    // Below-neighbour row: the incoming row while streaming, edge row during flush.
    always_comb begin
        below_c = bus.in_data;
        if (state_q == FLUSH) begin
`ifdef GOL_TORUS_EN
            below_c = tail_q ? row1_q : row0_q;
`else
            below_c = '0;
`endif
        end
    end

    gol_row_step #(.WIDTH(WIDTH)) u_step (
        .above_i   (above_q),
        .cur_i     (cur_q),
        .below_i   (below_c),
        .birth_i   (birth_q),
        .survive_i (survive_q),
        .next_c    (step_c)
    );

    // Next-state, window shift and output register load.
    always_comb begin
        state_d     = state_q;
        above_d     = above_q;
        cur_d       = cur_q;
        out_data_d  = out_data_q;
        in_row_d    = in_row_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_last_d  = out_last_q;
        gen_d       = gen_q;
        birth_d     = birth_q;
        survive_d   = survive_q;
`ifdef GOL_TORUS_EN
        row0_d      = row0_q;
        row1_d      = row1_q;
        tail_d      = tail_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    above_d   = '0;
                    cur_d     = bus.in_data;
                    birth_d   = birth_mask;
                    survive_d = survive_mask;
                    in_row_d  = row_inc(in_row_q);
`ifdef GOL_TORUS_EN
                    row0_d    = bus.in_data;
`endif
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (accept_c) begin
                    above_d  = cur_q;
                    cur_d    = bus.in_data;
                    in_row_d = row_inc(in_row_q);
`ifdef GOL_TORUS_EN
                    row1_d   = bus.in_data;
                    state_d  = STREAM;
`else
                    out_data_d  = step_c;
                    out_row_d   = '0;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = (in_row_q == LAST_ROW) ? FLUSH : STREAM;
`endif
                end
            end
            STREAM: begin
                if (accept_c) begin
                    out_data_d  = step_c;
                    out_row_d   = in_row_q - ROW_W'(1);
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    above_d     = cur_q;
                    cur_d       = bus.in_data;
                    in_row_d    = row_inc(in_row_q);
                    if (in_row_q == LAST_ROW) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free_c) begin
                    out_data_d  = step_c;
                    out_valid_d = 1'b1;
`ifdef GOL_TORUS_EN
                    if (!tail_q) begin
                        out_row_d  = LAST_ROW;
                        out_last_d = 1'b0;
                        above_d    = cur_q;
                        cur_d      = row0_q;
                        tail_d     = 1'b1;
                    end else begin
                        out_row_d  = '0;
                        out_last_d = 1'b1;
                        tail_d     = 1'b0;
                        state_d    = DONE;
                    end
`else
                    out_row_d   = LAST_ROW;
                    out_last_d  = 1'b1;
                    state_d     = DONE;
`endif
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    gen_d      = gen_q + GEN_W'(1);
                    out_last_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, window buffers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            above_q     <= '0;
            cur_q       <= '0;
            out_data_q  <= '0;
            in_row_q    <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            gen_q       <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            busy_q      <= 1'b0;
            ready_en_q  <= 1'b0;
`ifdef GOL_TORUS_EN
            row0_q      <= '0;
            row1_q      <= '0;
            tail_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            above_q     <= above_d;
            cur_q       <= cur_d;
            out_data_q  <= out_data_d;
            in_row_q    <= in_row_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            gen_q       <= gen_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            busy_q      <= (state_d != IDLE);
            ready_en_q  <= 1'b1;
`ifdef GOL_TORUS_EN
            row0_q      <= row0_d;
            row1_q      <= row1_d;
            tail_q      <= tail_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign gen_count     = gen_q;

endmodule

// File: doc/gol_row_engine.md
Name: gol_row_engine

Overview:
- Streaming Game-of-Life generation engine, parametrised in grid width/height and in the life rule.
- Accepts the current generation one row per beat (valid/ready) and emits the next generation one row per beat through a 3-row sliding window.
- Birth/survive rules are runtime masks, so B3/S23, HighLife and others are supported.
- Sits between the frame store and the display/next-frame writer; replaces whole-grid evaluation with row-serial evaluation.

Parameters:
- WIDTH, 64, cells per row (bits per beat); ≥3.
- HEIGHT, 48, rows per generation; ≥2 (≥3 when GOL_TORUS_EN is defined; elaboration-time assertion).
- GEN_W, 16, width of the generation counter.
- ROW_W, $clog2(HEIGHT), width of the row index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- birth_mask  in  9  bit n set: dead cell with n live neighbours becomes live.
- survive_mask  in  9  bit n set: live cell with n live neighbours stays live.
- in_valid  in  1  input row valid.
- in_ready  out  1  engine accepts row.
- in_data  in  WIDTH  current-generation row; bit x = column x.
- out_valid  out  1  next-generation row valid.
- out_ready  in  1  sink accepts row.
- out_data  out  WIDTH  next-generation row.
- out_row  out  ROW_W  row index of out_data.
- out_last  out  1  final row of the generation.
- busy  out  1  frame in progress (state ≠ IDLE).
- gen_count  out  GEN_W  completed generations.

Behaviour:
- Reset (asserted low, asynchronous):
  - State → IDLE.
  - out_valid, out_last, busy, in_ready, gen_count, out_row, out_data and all row buffers → 0.
  - Reset mid-frame discards the partial frame; no output row is emitted.
- Handshakes:
  - A transfer occurs when valid && ready on the same edge.
  - out_valid, once high, holds with out_data/out_row/out_last stable until accepted.
  - in_ready = (state ∈ {IDLE, FILL, STREAM}) && (!out_valid || out_ready); accept and output drain in the same cycle are legal, giving 1 row/cycle throughput.
- Masks are captured into internal registers when row 0 is accepted; changes mid-frame take effect next frame.
- Input row counter: increments on each accept and wraps to 0 after HEIGHT-1.
- Cell rule:
  - n = 4-bit count of the 8 neighbours.
  - next = cur ? survive_mask[n] : birth_mask[n].
  - Cells outside the grid are dead (no wrap) on both column and row edges.
- States:
  - IDLE: accept row 0 into cur buffer, above = 0 → FILL.
  - FILL: accept row 1 into cur (row 0 moves to above). out row 0 (above=0, below=row1) is registered on the next cycle → STREAM. If HEIGHT=2, go to FLUSH instead.
  - STREAM: accepting row y (2 ≤ y ≤ HEIGHT-1) registers out row y-1 one cycle later. Window shifts above←cur←in. Accepting row HEIGHT-1 → FLUSH.
  - FLUSH: in_ready = 0. Register out row HEIGHT-1 (below = 0) with out_last = 1 once the output register is free → DONE.
  - DONE: on out_last handshake, gen_count += 1 (wraps modulo 2^GEN_W) → IDLE.
- Latency: accepted row y produces output row y-1 exactly one cycle later when the sink is ready; the final row appears ≥1 cycle after the last input.
- Output order: rows 0..HEIGHT-1, out_row monotonic.
- Backpressure: out_ready low stalls the window; no row is dropped or duplicated.
- in_valid is ignored in FLUSH/DONE.

Optional Feature:
- Macro: GOL_TORUS_EN.
- Defined: toroidal grid.
  - Column x-1/x+1 wrap modulo WIDTH; rows wrap modulo HEIGHT.
  - Rows 0 and 1 are retained in dedicated buffers.
  - Accepting row 1 emits nothing; accepting row y ≥ 2 emits row y-1.
  - FLUSH emits row HEIGHT-1 (below = saved row 0), then row 0 (above = row HEIGHT-1, below = saved row 1) with out_last.
  - Output order: 1..HEIGHT-1, 0; out_row identifies the row.
- Undefined: dead-border behaviour above; no extra buffers.

Decomposition:
- Shared package gol_pkg:
  - rule_mask_t (logic [8:0]).
  - RULE_B3 = 9'b000001000, RULE_S23 = 9'b000001100.
  - nbr_cnt_t (logic [3:0]).
  - State enum gol_state_e {IDLE, FILL, STREAM, FLUSH, DONE}.
- Sub-module gol_row_step: purely combinational (above, cur, below, birth, survive) → next row. It contains the per-column neighbour adders and the wrap/dead edge selection under GOL_TORUS_EN. The engine holds only the FSM, buffers and handshakes.

Test Plan:
- Blinker, WIDTH=8, HEIGHT=5, B3/S23: rows 1–3 = 8'h04 (vertical) → output rows 1–3 = 8'h00, 8'h0E, 8'h00; out_last on row 4; gen_count=1.
- Full-throughput stream with out_ready=1: 5 rows on consecutive cycles → 5 output rows on consecutive cycles, in_ready never low before FLUSH.
- Random out_ready backpressure on a 10-generation glider → outputs match a software model; no drop or duplicate; out_data stable while stalled.
- HighLife masks (birth 9'h048, survive 9'h00C) changed mid-frame at row 2 → frame uses old rule, next frame uses new.
- Reset low during row 3 of a frame → out_valid=0, busy=0, gen_count unchanged at 0. Next frame from row 0 is correct.
- GOL_TORUS_EN, WIDTH=8, HEIGHT=4: glider crossing the corner → wraps correctly; out_row order 1, 2, 3, 0; out_last with out_row=0.
